// File: rtl/addr_xlate_if.sv
// addr_xlate_if: request and response valid/ready channels of the translation stage
interface addr_xlate_if #(parameter int TLBNUM = 16);
  localparam int IW = $clog2(TLBNUM);
  logic          req_valid;
  logic          req_ready;
  logic [31:0]   req_va;
  logic [1:0]    req_op;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [31:0]   rsp_pa;
  logic [1:0]    rsp_mat;
  logic [2:0]    rsp_ecode;
  logic [IW-1:0] rsp_tlb_index;
  logic [31:0]   rsp_va;
  modport master (
    output req_valid, req_va, req_op, rsp_ready,
    input  req_ready, rsp_valid, rsp_pa, rsp_mat, rsp_ecode, rsp_tlb_index, rsp_va
  );
  modport slave (
    input  req_valid, req_va, req_op, rsp_ready,
    output req_ready, rsp_valid, rsp_pa, rsp_mat, rsp_ecode, rsp_tlb_index, rsp_va
  );
endinterface

// File: rtl/addr_xlate.sv
// addr_xlate: two-stage virtual-to-physical translation (DA / DMW / TLB) with exception checks
module addr_xlate #(
  parameter int TLBNUM = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      flush,
  input  logic                      csr_crmd_da,
  input  logic                      csr_crmd_pg,
  input  logic [1:0]                csr_crmd_plv,
  input  logic [1:0]                csr_crmd_datm,
  input  logic [9:0]                csr_asid,
  input  logic [31:0]               csr_dmw0,
  input  logic [31:0]               csr_dmw1,
  output logic [18:0]               tlb_vppn,
  output logic                      tlb_va_bit12,
  output logic [9:0]                tlb_asid,
  input  logic                      tlb_found,
  input  logic [$clog2(TLBNUM)-1:0] tlb_index,
  input  logic [19:0]               tlb_ppn,
  input  logic [5:0]                tlb_ps,
  input  logic [1:0]                tlb_plv,
  input  logic [1:0]                tlb_mat,
  input  logic                      tlb_d,
  input  logic                      tlb_v,
  addr_xlate_if.slave               bus
);
  localparam int IW = $clog2(TLBNUM);
  logic          x1_valid;
  logic [31:0]   x1_va;
  logic [1:0]    x1_op;
  logic          out_adv;
  logic          da_mode;
  logic          dmw0_hit;
  logic          dmw1_hit;
  logic          tlb_path;
  logic          is_fetch;
  logic          is_store;
  logic [2:0]    tlb_ec;
  logic [2:0]    ecode_c;
  logic [31:0]   tlb_pa;
  logic [31:0]   raw_pa;
  logic [1:0]    raw_mat;
  logic [31:0]   pa_c;
  logic [1:0]    mat_c;
  logic [IW-1:0] idx_c;
  logic          unused_dmw_bits;

  // a window matches on VSEG and only grants PLV0 or PLV3 through its enable bits
  function automatic logic dmw_hit(input logic [31:0] dmw, input logic [2:0] vseg, input logic [1:0] plv);
    return dmw[31:29] == vseg && ((plv == 2'd0 && dmw[0]) || (plv == 2'd3 && dmw[3]));
  endfunction

  assign unused_dmw_bits = ^{csr_dmw0[28], csr_dmw0[24:6], csr_dmw0[2:1],
                             csr_dmw1[28], csr_dmw1[24:6], csr_dmw1[2:1]};

  // handshake control: a flush blocks new requests for its cycle
  always_comb begin
    out_adv       = !bus.rsp_valid | bus.rsp_ready;
    bus.req_ready = (!x1_valid | out_adv) & !flush;
  end

  // TLB search port follows the X1 register
  always_comb begin
    tlb_vppn     = x1_va[31:13];
    tlb_va_bit12 = x1_va[12];
    tlb_asid     = csr_asid;
  end

  // translation mode select; DA=PG=0 and DA=PG=1 both fall back to direct address
  always_comb begin
    da_mode  = csr_crmd_da | !csr_crmd_pg;
    dmw0_hit = !da_mode & dmw_hit(csr_dmw0, x1_va[31:29], csr_crmd_plv);
    dmw1_hit = !da_mode & !dmw0_hit & dmw_hit(csr_dmw1, x1_va[31:29], csr_crmd_plv);
    tlb_path = !da_mode & !dmw0_hit & !dmw1_hit;
    is_fetch = x1_op == 2'd0;
    is_store = x1_op == 2'd2;
  end

  // TLB exception priority: refill, invalid page, privilege, then modify
  always_comb begin
    tlb_ec  = !tlb_found ? 3'd1 :
              !tlb_v ? (is_fetch ? 3'd4 : is_store ? 3'd3 : 3'd2) :
              csr_crmd_plv > tlb_plv ? 3'd6 :
              (is_store & !tlb_d) ? 3'd5 : 3'd0;
    ecode_c = tlb_path ? tlb_ec : 3'd0;
    tlb_pa  = tlb_ps == 6'd22 ? {tlb_ppn[19:10], x1_va[21:0]} : {tlb_ppn, x1_va[11:0]};
    raw_pa  = da_mode ? x1_va :
              dmw0_hit ? {csr_dmw0[27:25], x1_va[28:0]} :
              dmw1_hit ? {csr_dmw1[27:25], x1_va[28:0]} : tlb_pa;
    raw_mat = da_mode ? csr_crmd_datm : dmw0_hit ? csr_dmw0[5:4] : dmw1_hit ? csr_dmw1[5:4] : tlb_mat;
    pa_c    = |ecode_c ? 32'd0 : raw_pa;
    mat_c   = |ecode_c ? 2'd0 : raw_mat;
    idx_c   = (tlb_path & tlb_found) ? tlb_index : '0;
  end

  // X1 stage: holds while the output stage is stalled
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      x1_valid <= 1'b0;
      x1_va    <= '0;
      x1_op    <= '0;
    end else begin
      x1_valid <= flush ? 1'b0 : bus.req_ready ? bus.req_valid : x1_valid;
      if (bus.req_ready & bus.req_valid) begin
        x1_va <= bus.req_va;
        x1_op <= bus.req_op;
      end
    end

  // OUT stage: captures the X1 result whenever the consumer can take a new one
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      bus.rsp_valid     <= 1'b0;
      bus.rsp_pa        <= '0;
      bus.rsp_mat       <= '0;
      bus.rsp_ecode     <= '0;
      bus.rsp_tlb_index <= '0;
      bus.rsp_va        <= '0;
    end else begin
      bus.rsp_valid <= flush ? 1'b0 : out_adv ? x1_valid : bus.rsp_valid;
      if (!flush & out_adv & x1_valid) begin
        bus.rsp_pa        <= pa_c;
        bus.rsp_mat       <= mat_c;
        bus.rsp_ecode     <= ecode_c;
        bus.rsp_tlb_index <= idx_c;
        bus.rsp_va        <= x1_va;
      end
    end
endmodule

// File: tb/tb_addr_xlate.sv
// tb_addr_xlate: table-driven translation vectors plus back-pressure, flush and reset sequences
module tb_addr_xlate;
  localparam int TLBNUM = 16;
  typedef struct {
    logic        da;
    logic        pg;
    logic [1:0]  plv;
    logic [1:0]  datm;
    logic [31:0] dmw0;
    logic [31:0] dmw1;
    logic [31:0] va;
    logic [1:0]  op;
    logic        found;
    logic [3:0]  idx;
    logic [19:0] ppn;
    logic [5:0]  ps;
    logic [1:0]  tplv;
    logic [1:0]  tmat;
    logic        d;
    logic        v;
    logic [31:0] e_pa;
    logic [1:0]  e_mat;
    logic [2:0]  e_ec;
    logic [3:0]  e_idx;
  } vec_t;

  logic        clk;
  logic        reset;
  logic        flush;
  logic        csr_crmd_da;
  logic        csr_crmd_pg;
  logic [1:0]  csr_crmd_plv;
  logic [1:0]  csr_crmd_datm;
  logic [9:0]  csr_asid;
  logic [31:0] csr_dmw0;
  logic [31:0] csr_dmw1;
  logic [18:0] tlb_vppn;
  logic        tlb_va_bit12;
  logic [9:0]  tlb_asid;
  logic        tlb_found;
  logic [3:0]  tlb_index;
  logic [19:0] tlb_ppn;
  logic [5:0]  tlb_ps;
  logic [1:0]  tlb_plv;
  logic [1:0]  tlb_mat;
  logic        tlb_d;
  logic        tlb_v;
  int          checks;
  int          errors;
  vec_t        vecs [20];

  addr_xlate_if #(.TLBNUM(TLBNUM)) bus();

  addr_xlate #(.TLBNUM(TLBNUM)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .csr_crmd_da(csr_crmd_da), .csr_crmd_pg(csr_crmd_pg), .csr_crmd_plv(csr_crmd_plv),
    .csr_crmd_datm(csr_crmd_datm), .csr_asid(csr_asid), .csr_dmw0(csr_dmw0), .csr_dmw1(csr_dmw1),
    .tlb_vppn(tlb_vppn), .tlb_va_bit12(tlb_va_bit12), .tlb_asid(tlb_asid),
    .tlb_found(tlb_found), .tlb_index(tlb_index), .tlb_ppn(tlb_ppn), .tlb_ps(tlb_ps),
    .tlb_plv(tlb_plv), .tlb_mat(tlb_mat), .tlb_d(tlb_d), .tlb_v(tlb_v),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic set_env(input vec_t v);
    csr_crmd_da   = v.da;
    csr_crmd_pg   = v.pg;
    csr_crmd_plv  = v.plv;
    csr_crmd_datm = v.datm;
    csr_dmw0      = v.dmw0;
    csr_dmw1      = v.dmw1;
    tlb_found     = v.found;
    tlb_index     = v.idx;
    tlb_ppn       = v.ppn;
    tlb_ps        = v.ps;
    tlb_plv       = v.tplv;
    tlb_mat       = v.tmat;
    tlb_d         = v.d;
    tlb_v         = v.v;
  endtask

  task automatic run_vec(input vec_t v, input int n);
    @(negedge clk);
    set_env(v);
    bus.req_va    = v.va;
    bus.req_op    = v.op;
    bus.req_valid = 1'b1;
    bus.rsp_ready = 1'b1;
    #1 chk($sformatf("v%0d_req_ready", n), bus.req_ready, 1);
    @(negedge clk);
    bus.req_valid = 1'b0;
    chk($sformatf("v%0d_vppn", n), tlb_vppn, v.va[31:13]);
    chk($sformatf("v%0d_bit12", n), tlb_va_bit12, v.va[12]);
    chk($sformatf("v%0d_early_valid", n), bus.rsp_valid, 0);
    @(negedge clk);
    chk($sformatf("v%0d_valid", n), bus.rsp_valid, 1);
    chk($sformatf("v%0d_pa", n), bus.rsp_pa, v.e_pa);
    chk($sformatf("v%0d_mat", n), bus.rsp_mat, v.e_mat);
    chk($sformatf("v%0d_ecode", n), bus.rsp_ecode, v.e_ec);
    chk($sformatf("v%0d_idx", n), bus.rsp_tlb_index, v.e_idx);
    chk($sformatf("v%0d_va", n), bus.rsp_va, v.va);
  endtask

  initial begin
    int sent;
    int got;
    logic seen;
    checks = 0;
    errors = 0;
    //              da pg plv datm dmw0          dmw1          va            op found idx ppn       ps     tplv tmat d  v   e_pa          e_mat e_ec e_idx
    vecs[0]  = '{1, 0, 0, 1, 32'h0,        32'h0,        32'h1C00_1234, 1, 0, 0, 20'h0,     6'd12, 0, 0, 0, 0, 32'h1C00_1234, 1, 0, 0};
    vecs[1]  = '{0, 1, 0, 0, 32'h8000_0011, 32'h0,        32'h9000_0040, 1, 1, 5, 20'h12345, 6'd12, 3, 2, 1, 1, 32'h1000_0040, 1, 0, 0};
    vecs[2]  = '{0, 1, 3, 0, 32'h8000_0011, 32'h0,        32'h9000_0040, 1, 1, 5, 20'h12345, 6'd12, 3, 2, 1, 1, 32'h1234_5040, 2, 0, 5};
    vecs[3]  = '{0, 1, 3, 0, 32'h0,        32'h0,        32'h0040_2ABC, 2, 1, 3, 20'h12345, 6'd12, 3, 1, 1, 1, 32'h1234_5ABC, 1, 0, 3};
    vecs[4]  = '{0, 1, 3, 0, 32'h0,        32'h0,        32'h0040_2ABC, 2, 1, 3, 20'h12345, 6'd12, 3, 1, 0, 1, 32'h0,         0, 5, 3};
    vecs[5]  = '{0, 1, 0, 0, 32'h0,        32'h0,        32'h0123_4567, 1, 1, 7, 20'hABC00, 6'd22, 0, 1, 0, 1, 32'hABE3_4567, 1, 0, 7};
    vecs[6]  = '{0, 1, 0, 0, 32'h0,        32'h0,        32'h0123_4567, 1, 0, 9, 20'hABC00, 6'd22, 0, 1, 1, 1, 32'h0,         0, 1, 0};
    vecs[7]  = '{0, 1, 0, 0, 32'h0,        32'h0,        32'h0000_1000, 0, 1, 2, 20'h12345, 6'd12, 0, 1, 1, 0, 32'h0,         0, 4, 2};
    vecs[8]  = '{0, 1, 0, 0, 32'h0,        32'h0,        32'h0000_1000, 2, 1, 2, 20'h12345, 6'd12, 0, 1, 0, 0, 32'h0,         0, 3, 2};
    vecs[9]  = '{0, 1, 0, 0, 32'h0,        32'h0,        32'h0000_1000, 1, 1, 2, 20'h12345, 6'd12, 0, 1, 1, 0, 32'h0,         0, 2, 2};
    vecs[10] = '{0, 1, 0, 0, 32'h0,        32'h0,        32'h0000_1000, 3, 1, 2, 20'h12345, 6'd12, 0, 1, 1, 0, 32'h0,         0, 2, 2};
    vecs[11] = '{0, 1, 3, 0, 32'h0,        32'h0,        32'h0000_1000, 1, 1, 2, 20'h12345, 6'd12, 0, 1, 1, 1, 32'h0,         0, 6, 2};
    vecs[12] = '{0, 1, 3, 0, 32'h0,        32'h0,        32'h0000_1000, 2, 1, 2, 20'h12345, 6'd12, 0, 1, 0, 1, 32'h0,         0, 6, 2};
    vecs[13] = '{0, 1, 0, 0, 32'h0,        32'h0,        32'h0000_1000, 3, 1, 2, 20'h12345, 6'd12, 0, 1, 0, 1, 32'h1234_5000, 1, 0, 2};
    vecs[14] = '{0, 1, 3, 0, 32'h8000_0011, 32'hA200_0028, 32'hA000_1000, 1, 0, 4, 20'h0,     6'd12, 0, 0, 0, 0, 32'h2000_1000, 2, 0, 0};
    vecs[15] = '{0, 1, 0, 0, 32'h8000_0011, 32'h8400_0031, 32'h8000_0100, 1, 0, 4, 20'h0,     6'd12, 0, 0, 0, 0, 32'h0000_0100, 1, 0, 0};
    vecs[16] = '{0, 0, 0, 2, 32'h8000_0011, 32'h0,        32'h9000_0040, 1, 1, 4, 20'h12345, 6'd12, 0, 1, 1, 1, 32'h9000_0040, 2, 0, 0};
    vecs[17] = '{1, 1, 0, 3, 32'h8000_0011, 32'h0,        32'h9000_0040, 2, 1, 4, 20'h12345, 6'd12, 0, 1, 0, 0, 32'h9000_0040, 3, 0, 0};
    vecs[18] = '{0, 1, 1, 0, 32'h8000_0019, 32'h8000_0019, 32'h8000_0000, 1, 0, 6, 20'h0,     6'd12, 0, 0, 0, 0, 32'h0,         0, 1, 0};
    vecs[19] = '{0, 1, 3, 0, 32'h8E00_0038, 32'h0,        32'h9FFF_FFFC, 2, 0, 1, 20'h0,     6'd12, 0, 0, 0, 0, 32'hFFFF_FFFC, 3, 0, 0};

    reset         = 1'b1;
    flush         = 1'b0;
    csr_asid      = 10'h2A5;
    bus.req_valid = 1'b0;
    bus.req_va    = '0;
    bus.req_op    = '0;
    bus.rsp_ready = 1'b1;
    set_env(vecs[0]);
    @(negedge clk);
    @(negedge clk);
    chk("rst_valid", bus.rsp_valid, 0);
    chk("rst_pa", bus.rsp_pa, 0);
    chk("rst_mat", bus.rsp_mat, 0);
    chk("rst_ecode", bus.rsp_ecode, 0);
    chk("rst_idx", bus.rsp_tlb_index, 0);
    chk("rst_va", bus.rsp_va, 0);
    reset = 1'b0;
    #1 chk("rst_req_ready", bus.req_ready, 1);
    chk("asid", tlb_asid, 10'h2A5);

    for (int i = 0; i < 20; i++) run_vec(vecs[i], i);

    // back-pressure: four requests, consumer stalled for the first three cycles
    set_env(vecs[0]);
    sent = 0;
    got  = 0;
    for (int c = 0; c < 40 && got < 4; c++) begin
      @(negedge clk);
      bus.rsp_ready = c >= 3;
      bus.req_valid = sent < 4;
      bus.req_va    = 32'h100 + 32'(sent * 4);
      bus.req_op    = 2'd1;
      #1;
      if (c == 2) begin
        chk("bp_req_ready_low", bus.req_ready, 0);
        chk("bp_accepts", sent, 2);
      end
      if (bus.rsp_valid && bus.rsp_ready) begin
        chk($sformatf("bp_rsp%0d_pa", got), bus.rsp_pa, 32'h100 + 32'(got * 4));
        got++;
      end
      if (bus.req_valid && bus.req_ready) sent++;
    end
    chk("bp_rsp_count", got, 4);
    @(negedge clk);
    bus.req_valid = 1'b0;
    chk("bp_no_dup", bus.rsp_valid, 0);

    // flush with X1 and OUT full and a new request offered
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    bus.req_valid = 1'b1;
    bus.req_va    = 32'hA0;
    @(negedge clk);
    bus.req_va    = 32'hB0;
    @(negedge clk);
    chk("fl_pre_valid", bus.rsp_valid, 1);
    bus.req_va    = 32'hC0;
    flush         = 1'b1;
    #1 chk("fl_req_ready", bus.req_ready, 0);
    @(negedge clk);
    flush         = 1'b0;
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    chk("fl_valid", bus.rsp_valid, 0);
    seen = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      seen = seen | bus.rsp_valid;
    end
    chk("fl_no_rsp", seen, 0);
    chk("fl_req_ready_after", bus.req_ready, 1);

    // asynchronous reset with a held TLB response in OUT
    @(negedge clk);
    set_env('{0, 1, 0, 0, 32'h0, 32'h0, 32'h0, 0, 1, 11, 20'h12345, 6'd12, 0, 3, 1, 1, 32'h0, 0, 0, 0});
    bus.rsp_ready = 1'b0;
    bus.req_valid = 1'b1;
    bus.req_va    = 32'h0040_3000;
    bus.req_op    = 2'd1;
    @(negedge clk);
    bus.req_valid = 1'b0;
    @(negedge clk);
    chk("ar_pre_pa", bus.rsp_pa, 32'h1234_5000);
    chk("ar_pre_idx", bus.rsp_tlb_index, 11);
    #2 reset = 1'b1;
    #1;
    chk("ar_valid", bus.rsp_valid, 0);
    chk("ar_pa", bus.rsp_pa, 0);
    chk("ar_mat", bus.rsp_mat, 0);
    chk("ar_ecode", bus.rsp_ecode, 0);
    chk("ar_idx", bus.rsp_tlb_index, 0);
    chk("ar_va", bus.rsp_va, 0);
    @(negedge clk);
    reset = 1'b0;
    bus.rsp_ready = 1'b1;
    #1 chk("ar_req_ready", bus.req_ready, 1);
    @(negedge clk);
    chk("ar_no_rsp", bus.rsp_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
